// File: rtl/pair_pkg.sv
// rtl/pair_pkg.sv - shared widths, point/connection types and FSM encoding for the pair generator
package pair_pkg;
  localparam int NUM_POINTS = 1000;
  localparam int DIM_W      = 17;
  localparam int IDX_W      = $clog2(NUM_POINTS);
  localparam int DIST_W     = 2*DIM_W + 2;
  localparam int SUM_W      = DIST_W + 2*IDX_W;

  typedef struct packed {
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic [DIM_W-1:0] z;
  } point_t;

  typedef struct packed {
    logic [DIST_W-1:0] distance;
    logic [IDX_W-1:0]  pointa;
    logic [IDX_W-1:0]  pointb;
  } conn_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_A, ST_LAT_A, ST_STREAM, ST_DRAIN, ST_DONE
  } state_t;

  function automatic logic [DIM_W-1:0] abs_diff(input logic [DIM_W-1:0] a, input logic [DIM_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/sq_dist_pipe.sv
// rtl/sq_dist_pipe.sv - three register stages: |delta|, squares, summed distance; optional PAIR_GEN_CHECKSUM_EN taps
module sq_dist_pipe
  import pair_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  point_t           a,
  input  point_t           b,
  input  logic [IDX_W-1:0] tag_a,
  input  logic [IDX_W-1:0] tag_b,
  input  logic             vld_in,
  output logic             pipe_busy,
  output conn_t            conn_out,
  output logic             vld_out
`ifdef PAIR_GEN_CHECKSUM_EN
  ,
  output logic [DIST_W-1:0] dist_nxt,
  output logic              vld_nxt
`endif
);
  logic [DIM_W-1:0]   r_dx, r_dy, r_dz;
  logic [2*DIM_W-1:0] r_sx, r_sy, r_sz;
  logic [IDX_W-1:0]   r_ta1, r_tb1, r_ta2, r_tb2;
  logic               r_v1, r_v2;
  logic [DIST_W-1:0]  w_sum;

  assign w_sum     = DIST_W'(r_sx) + DIST_W'(r_sy) + DIST_W'(r_sz);
  assign pipe_busy = r_v1 | r_v2;
`ifdef PAIR_GEN_CHECKSUM_EN
  assign dist_nxt = w_sum;
  assign vld_nxt  = r_v2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      vld_out  <= 1'b0;
      conn_out <= '0;
    end else begin
      r_v1    <= vld_in;
      r_v2    <= r_v1;
      vld_out <= r_v2;
      if (vld_in) begin
        r_dx  <= abs_diff(a.x, b.x);
        r_dy  <= abs_diff(a.y, b.y);
        r_dz  <= abs_diff(a.z, b.z);
        r_ta1 <= tag_a;
        r_tb1 <= tag_b;
      end
      if (r_v1) begin
        r_sx  <= (2*DIM_W)'(r_dx) * (2*DIM_W)'(r_dx);
        r_sy  <= (2*DIM_W)'(r_dy) * (2*DIM_W)'(r_dy);
        r_sz  <= (2*DIM_W)'(r_dz) * (2*DIM_W)'(r_dz);
        r_ta2 <= r_ta1;
        r_tb2 <= r_tb1;
      end
      // conn_out only moves on a valid beat, otherwise it holds the last pair
      if (r_v2) begin
        conn_out.distance <= w_sum;
        conn_out.pointa   <= r_ta2;
        conn_out.pointb   <= r_tb2;
      end
    end
  end
endmodule

// File: rtl/pair_dist_gen.sv
// rtl/pair_dist_gen.sv - point store + (i<j) pair enumerator feeding the min-sort chain; PAIR_GEN_CHECKSUM_EN adds dist_sum
module pair_dist_gen
  import pair_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pt_clr,
  input  logic             pt_wr_vld,
  input  logic [DIM_W-1:0] pt_wr_x,
  input  logic [DIM_W-1:0] pt_wr_y,
  input  logic [DIM_W-1:0] pt_wr_z,
  output logic [IDX_W:0]   pt_cnt,
  output logic             pt_ovf,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output conn_t            conn_out,
  output logic             conn_out_vld
`ifdef PAIR_GEN_CHECKSUM_EN
  ,
  output logic [SUM_W-1:0] dist_sum
`endif
);
  point_t           r_ram [NUM_POINTS];
  point_t           r_rd, r_a;
  logic [IDX_W-1:0] r_i, r_j, r_ti, r_tj;
  logic             r_rv;
  state_t           r_state, w_next;
  logic             w_idle, w_issue, w_row_end, w_last_row, w_room, w_pipe_busy;
  logic [IDX_W-1:0] w_addr;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_room     = (pt_cnt < (IDX_W+1)'(NUM_POINTS));
  assign w_row_end  = ({1'b0, r_j} == pt_cnt - (IDX_W+1)'(1));
  assign w_last_row = ({1'b0, r_i} == pt_cnt - (IDX_W+1)'(2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_cnt <= '0;
      pt_ovf <= 1'b0;
    end else if (w_idle) begin
      if (pt_clr) begin
        pt_cnt <= '0;
        pt_ovf <= 1'b0;
      end else if (pt_wr_vld) begin
        if (w_room) pt_cnt <= pt_cnt + 1'b1;
        else        pt_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_idle && !pt_clr && pt_wr_vld && w_room)
      r_ram[pt_cnt[IDX_W-1:0]] <= '{x: pt_wr_x, y: pt_wr_y, z: pt_wr_z};
    r_rd <= r_ram[w_addr];
    if (r_state == ST_LAT_A) r_a <= r_rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_rv    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rv    <= w_issue;
      r_ti    <= r_i;
      r_tj    <= r_j;
      case (r_state)
        ST_IDLE:   if (start) r_i <= '0;
        ST_LAT_A:  r_j <= r_i + 1'b1;
        ST_STREAM: begin
          if (!w_row_end)       r_j <= r_j + 1'b1;
          else if (!w_last_row) r_i <= r_i + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Count check happens in RD_A so a write coinciding with start is already counted
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_RD_A;
      ST_RD_A:   w_next = (pt_cnt < (IDX_W+1)'(2)) ? ST_DONE : ST_LAT_A;
      ST_LAT_A:  w_next = ST_STREAM;
      ST_STREAM: if (w_row_end) w_next = w_last_row ? ST_DRAIN : ST_RD_A;
      ST_DRAIN:  if (!(r_rv || w_pipe_busy)) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_issue = (r_state == ST_STREAM);
    w_addr  = w_issue ? r_j : r_i;
    busy    = !(w_idle || r_state == ST_DONE);
    done    = (r_state == ST_DONE);
  end

`ifdef PAIR_GEN_CHECKSUM_EN
  logic [DIST_W-1:0] w_dist_nxt;
  logic              w_vld_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n)                dist_sum <= '0;
    else if (w_idle && start)  dist_sum <= '0;
    else if (w_vld_nxt)        dist_sum <= dist_sum + SUM_W'(w_dist_nxt);
  end
`endif

  sq_dist_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (r_a),
    .b         (r_rd),
    .tag_a     (r_ti),
    .tag_b     (r_tj),
    .vld_in    (r_rv),
    .pipe_busy (w_pipe_busy),
    .conn_out  (conn_out),
    .vld_out   (conn_out_vld)
`ifdef PAIR_GEN_CHECKSUM_EN
    ,
    .dist_nxt  (w_dist_nxt),
    .vld_nxt   (w_vld_nxt)
`endif
  );
endmodule

// File: tb/tb_pair_dist_gen.sv
// tb/tb_pair_dist_gen.sv - directed/random bench for pair_dist_gen against an enumerate-all-pairs model
module tb_pair_dist_gen;
  import pair_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n, pt_clr, pt_wr_vld, start;
  logic [DIM_W-1:0] pt_wr_x, pt_wr_y, pt_wr_z;
  logic [IDX_W:0]   pt_cnt;
  logic             pt_ovf, busy, done, conn_out_vld;
  conn_t            conn_out;
`ifdef PAIR_GEN_CHECKSUM_EN
  logic [SUM_W-1:0] dist_sum;
  logic [SUM_W-1:0] sum_at_done;
`endif

  always #5 clk = ~clk;

  pair_dist_gen dut (
    .clk(clk), .rst_n(rst_n), .pt_clr(pt_clr), .pt_wr_vld(pt_wr_vld),
    .pt_wr_x(pt_wr_x), .pt_wr_y(pt_wr_y), .pt_wr_z(pt_wr_z),
    .pt_cnt(pt_cnt), .pt_ovf(pt_ovf), .start(start), .busy(busy), .done(done),
    .conn_out(conn_out), .conn_out_vld(conn_out_vld)
`ifdef PAIR_GEN_CHECKSUM_EN
    , .dist_sum(dist_sum)
`endif
  );

  int     errors = 0, checks = 0;
  int     cyc = 0, start_cyc = -1, done_cyc = -1, last_beat_cyc = -1, done_cnt = 0;
  conn_t  beats[$];
  longint px[$], py[$], pz[$];

  always @(negedge clk) begin
    cyc++;
    if (start && !busy) start_cyc = cyc;
    if (conn_out_vld) begin
      beats.push_back(conn_out);
      last_beat_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef PAIR_GEN_CHECKSUM_EN
      sum_at_done = dist_sum;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_dist(input int a, input int b);
    longint dx, dy, dz;
    dx = px[a] - px[b]; if (dx < 0) dx = -dx;
    dy = py[a] - py[b]; if (dy < 0) dy = -dy;
    dz = pz[a] - pz[b]; if (dz < 0) dz = -dz;
    return dx*dx + dy*dy + dz*dz;
  endfunction

  task automatic load_pt(input longint x, input longint y, input longint z);
    pt_wr_vld = 1'b1;
    pt_wr_x = DIM_W'(x); pt_wr_y = DIM_W'(y); pt_wr_z = DIM_W'(z);
    tick();
    pt_wr_vld = 1'b0;
    if (px.size() < NUM_POINTS) begin
      px.push_back(x); py.push_back(y); pz.push_back(z);
    end
  endtask

  task automatic load_rand(input int n);
    for (int k = 0; k < n; k++)
      load_pt($urandom_range(0, 131071), $urandom_range(0, 131071), $urandom_range(0, 131071));
  endtask

  task automatic clr();
    pt_clr = 1'b1;
    tick();
    pt_clr = 1'b0;
    px.delete(); py.delete(); pz.delete();
  endtask

  task automatic start_run();
    beats.delete();
    done_cnt = 0;
    done_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    tick();
  endtask

  // Expected beats come from a plain i<j enumeration of the model's point list
  task automatic check_run(input string tag);
    int n = px.size();
    int k = 0;
    conn_t e;
    check({tag, "_beats"}, 64'(beats.size()), 64'(n*(n-1)/2));
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++) begin
        e.distance = DIST_W'(ref_dist(i, j));
        e.pointa   = IDX_W'(i);
        e.pointb   = IDX_W'(j);
        if (k < beats.size()) check($sformatf("%s_beat%0d", tag, k), 64'(beats[k]), 64'(e));
        k++;
      end
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    if (n >= 2) begin
      check({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(n*(n-1)/2 + 2*(n-1) + 5));
      check({tag, "_done_after_last"}, 64'(done_cyc - last_beat_cyc), 64'd1);
    end else begin
      check({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'd2);
    end
  endtask

  initial begin
    rst_n = 1'b0; pt_clr = 1'b0; pt_wr_vld = 1'b0; start = 1'b0;
    pt_wr_x = '0; pt_wr_y = '0; pt_wr_z = '0;
    tick(); tick();
    check("rst_conn_out", 64'(conn_out), 64'd0);
    check("rst_vld", 64'(conn_out_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cnt", 64'(pt_cnt), 64'd0);
    check("rst_ovf", 64'(pt_ovf), 64'd0);
`ifdef PAIR_GEN_CHECKSUM_EN
    check("rst_sum", 64'(dist_sum), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Three hand-computed points: distances 9, 25, 12
    load_pt(0, 0, 0); load_pt(1, 2, 2); load_pt(3, 0, 4);
    start_run();
    wait_done("s1");
    check_run("s1");
    check("s1_cnt", 64'(pt_cnt), 64'd3);
    if (beats.size() == 3) begin
      check("s1_d01", 64'(beats[0].distance), 64'd9);
      check("s1_d02", 64'(beats[1].distance), 64'd25);
      check("s1_d12", 64'(beats[2].distance), 64'd12);
    end
`ifdef PAIR_GEN_CHECKSUM_EN
    check("s1_sum", 64'(sum_at_done), 64'd46);
`endif
    start_run();
    wait_done("s1b");
    check_run("s1b");
`ifdef PAIR_GEN_CHECKSUM_EN
    check("s1b_sum", 64'(sum_at_done), 64'd46);
`endif

    // Full-scale coordinates: widest possible distance
    clr();
    load_pt(0, 0, 0); load_pt(131071, 131071, 131071);
    start_run();
    wait_done("s2");
    check_run("s2");
    if (beats.size() == 1) check("s2_max", 64'(beats[0].distance), 64'd51538821123);
`ifdef PAIR_GEN_CHECKSUM_EN
    check("s2_sum", 64'(sum_at_done), 64'd51538821123);
`endif

    // Degenerate counts
    clr();
    start_run();
    wait_done("s3n0");
    check_run("s3n0");
    load_pt(5, 6, 7);
    start_run();
    wait_done("s3n1");
    check_run("s3n1");

    // Capacity and overflow
    clr();
    load_rand(NUM_POINTS);
    check("s4_cnt_full", 64'(pt_cnt), 64'(NUM_POINTS));
    check("s4_ovf_full", 64'(pt_ovf), 64'd0);
    load_pt(1, 1, 1);
    check("s4_cnt_ovf", 64'(pt_cnt), 64'(NUM_POINTS));
    check("s4_ovf_set", 64'(pt_ovf), 64'd1);
    clr();
    check("s4_cnt_clr", 64'(pt_cnt), 64'd0);
    check("s4_ovf_clr", 64'(pt_ovf), 64'd0);

    // Random 5 points, with start/write pulses during busy that must be ignored
    load_rand(5);
    start_run();
    tick(); tick(); tick();
    start = 1'b1; pt_wr_vld = 1'b1;
    pt_wr_x = DIM_W'($urandom_range(0, 131071)); pt_wr_y = '0; pt_wr_z = '0;
    tick();
    start = 1'b0; pt_wr_vld = 1'b0;
    wait_done("s5");
    check_run("s5");
    check("s5_cnt", 64'(pt_cnt), 64'd5);

    // Reset during the run at the 4th beat
    clr();
    load_rand(5);
    start_run();
    begin
      int n = 0;
      while (beats.size() < 4 && n < 200) begin
        @(negedge clk); #1;
        n++;
      end
    end
    check("s6_reached4", 64'(beats.size()), 64'd4);
    rst_n = 1'b0;
    tick();
    check("s6_rst_conn_out", 64'(conn_out), 64'd0);
    check("s6_rst_vld", 64'(conn_out_vld), 64'd0);
    check("s6_rst_busy", 64'(busy), 64'd0);
    check("s6_rst_done", 64'(done), 64'd0);
    check("s6_rst_cnt", 64'(pt_cnt), 64'd0);
    check("s6_rst_ovf", 64'(pt_ovf), 64'd0);
`ifdef PAIR_GEN_CHECKSUM_EN
    check("s6_rst_sum", 64'(dist_sum), 64'd0);
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("s6_no_more_beats", 64'(beats.size()), 64'd4);
    for (int k = 0; k < 4 && k < beats.size(); k++)
      check($sformatf("s6_beat%0d_dist", k), 64'(beats[k].distance),
            64'(ref_dist(int'(beats[k].pointa), int'(beats[k].pointb))));
    check("s6_no_done", 64'(done_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pair_dist_gen.md
Name: pair_dist_gen

Overview:
Source side of the sorted-connection chain. It stores up to NUM_POINTS 3-D points and enumerates every unordered pair (i<j). For each pair it computes the squared Euclidean distance and streams it as a conn_t beat (distance, pointa=i, pointb=j) into the head node of the min-sort chain, at one beat per cycle inside a row. The chain has no ready signal, so output valid is never back-pressured.

Parameters:
NUM_POINTS, 1000, capacity of the point store
DIM_W, 17, unsigned width of each coordinate

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
pt_clr  in  1  clears loaded point count and pt_ovf (ignored while busy)
pt_wr_vld  in  1  write one point at index = current count (ignored while busy)
pt_wr_x/pt_wr_y/pt_wr_z  in  DIM_W each  coordinates
pt_cnt  out  IDX_W+1  number of points loaded
pt_ovf  out  1  sticky: write attempted at count==NUM_POINTS
start  in  1  single-cycle pulse that launches enumeration over pt_cnt points
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the final beat leaves
conn_out  out  conn_t  {distance[DIST_W], pointa[IDX_W], pointb[IDX_W]}
conn_out_vld  out  1  beat valid

Behaviour:
- Reset: conn_out='0, conn_out_vld=0, busy=0, done=0, pt_cnt=0, pt_ovf=0, FSM=IDLE, pipeline valids cleared. Reset mid-run aborts with no further beats; point RAM contents are don't-care.
- Widths: IDX_W=$clog2(NUM_POINTS); DIST_W=2*DIM_W+2. Deltas are absolute differences of width DIM_W; squares are 2*DIM_W; the sum is zero-extended and cannot overflow.
- Load: on pt_wr_vld in IDLE, if pt_cnt<NUM_POINTS, write RAM[pt_cnt] and increment pt_cnt. Otherwise drop the write and set pt_ovf. pt_clr has priority over pt_wr_vld in the same cycle.
- start: accepted only in IDLE. start and pt_wr_vld in the same cycle: the write is applied first and start sees the updated count next cycle. If pt_cnt<2, go straight to DONE (no beats).
- FSM: IDLE -> RD_A -> LAT_A -> STREAM -> (RD_A | DRAIN) -> DONE -> IDLE.
  - RD_A: present address i to RAM (1-cycle registered read).
  - LAT_A: latch point i into reg_a; set j=i+1.
  - STREAM: issue address j each cycle, tagging (i,j).
    - At j==pt_cnt-1: if i==pt_cnt-2, go to DRAIN; else i++ and go to RD_A.
  - DRAIN: wait until pipeline valids are empty.
  - DONE: pulse done for 1 cycle, drop busy, return to IDLE.
- Pipeline: 4 fixed stages from issuing address j in STREAM to conn_out_vld=1 carrying that pair: RAM read, |delta| regs, square regs, sum reg = conn_out.
- Order is strictly i ascending, then j ascending. Beat count = N(N-1)/2. Each row costs 2 bubble cycles.
- The last beat appears in the final DRAIN cycle; done pulses the next cycle.
- conn_out holds its last value when conn_out_vld=0.

Optional Feature:
Macro PAIR_GEN_CHECKSUM_EN.
- Defined: adds output dist_sum [DIST_W+2*IDX_W-1:0]. It is cleared on accepted start and accumulates every distance emitted with conn_out_vld, updating on the same edge as the beat. The value is stable when done pulses. Reset value is 0.
- Undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared package (pair_pkg): IDX_W, DIST_W, point_t {x,y,z}, conn_t. sort_node already consumes this same conn_t.
- One sub-module: sq_dist_pipe (point_t a, point_t b, tag in, valid in -> 2-stage |delta|/square + sum, tag/valid out). The FSM, RAM and counters stay in pair_dist_gen.

Test Plan:
- Load (0,0,0),(1,2,2),(3,0,4); start -> exactly 3 beats in order (0,1,9),(0,2,25),(1,2,12). Then done for 1 cycle, pt_cnt=3.
- Load (0,0,0),(131071,131071,131071) -> single beat distance 51538821123, pointa=0, pointb=1. No truncation.
- pt_cnt=0 and pt_cnt=1 with start -> no conn_out_vld, done 2 cycles after start, busy never stuck.
- Load NUM_POINTS points, then one more write -> pt_ovf=1, pt_cnt=NUM_POINTS. Next pt_clr -> pt_cnt=0, pt_ovf=0.
- N=5 random points: exactly 10 beats in ascending (i,j). start and pt_wr_vld pulsed during busy are ignored; reset asserted at beat 4 -> no more beats, all outputs at reset values.
- With PAIR_GEN_CHECKSUM_EN, scenario 1 -> dist_sum=46 at done. Back-to-back run -> dist_sum restarts from 0.
